// File: rtl/ti_simon_pkg.sv
// ---------------------------------------------------------------------------
// ti_simon_pkg
// Shared types and constants for the TI Simon host-side share controller.
//   state_t        : controller FSM states (also exported on the debug port)
//   LFSR_TAPS      : Galois feedback mask for x^32+x^22+x^2+x+1
//   LFSR_RST       : LFSR reset value, also the substitute for a zero seed
//   *_DEFAULT      : default DATA_W / RND_W / TIMEOUT for the controller
//   wdog_w()       : watchdog counter width for a given TIMEOUT
// ---------------------------------------------------------------------------
package ti_simon_pkg;

    localparam int DATA_W_DEFAULT  = 256;
    localparam int RND_W_DEFAULT   = 32;
    localparam int TIMEOUT_DEFAULT = 16384;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam logic [31:0] LFSR_RST  = 32'h00000001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MASK  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    // Width of a counter that must reach TIMEOUT-1; never narrower than 1 bit.
    function automatic int wdog_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ti_lfsr_prng.sv
// ---------------------------------------------------------------------------
// ti_lfsr_prng
// 32-bit Galois LFSR mask generator, stepped RND_W times per enabled cycle.
// Ports:
//   CLK, rst : clock, asynchronous active-high reset (LFSR -> LFSR_RST)
//   seed     : seed value, used when load=1 (zero is replaced by LFSR_RST)
//   load     : load seed this cycle (already qualified by the caller)
//   step     : advance RND_W steps this cycle (already qualified)
//   rnd      : the RND_W output bits of the next RND_W steps; the first bit
//              produced sits in the MSB so the stream reads MSB-first
// ---------------------------------------------------------------------------
module ti_lfsr_prng
    import ti_simon_pkg::*;
#(
    parameter int RND_W = RND_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [31:0]      seed,
    input  logic             load,
    input  logic             step,
    output logic [RND_W-1:0] rnd
);

    logic [31:0]      lfsr_q;
    logic [31:0]      lfsr_nx;
    logic [RND_W-1:0] rnd_c;

    // Unrolled RND_W Galois steps: the output bit is the LSB before each shift.
    always_comb begin
        lfsr_nx = lfsr_q;
        rnd_c   = '0;
        for (int i = 0; i < RND_W; i++) begin
            rnd_c[RND_W-1-i] = lfsr_nx[0];
            lfsr_nx = lfsr_nx[0] ? ((lfsr_nx >> 1) ^ LFSR_TAPS) : (lfsr_nx >> 1);
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_RST;
        end else if (load) begin
            // An all-zero state would lock the LFSR at zero forever.
            lfsr_q <= (seed == 32'h0) ? LFSR_RST : seed;
        end else if (step) begin
            lfsr_q <= lfsr_nx;
        end
    end

    assign rnd = rnd_c;

endmodule

// File: rtl/ti_simon_share_ctrl.sv
// ---------------------------------------------------------------------------
// ti_simon_share_ctrl
// Host front end for the TI Simon core: masks one unmasked word into three
// Boolean shares, hands them to the core, and returns the core's result.
// Ports:
//   CLK, rst            : clock, asynchronous active-high reset
//   EN                  : global enable; every register holds when EN=0
//   seed, seed_ld       : PRNG seed load, honoured only in IDLE
//   in_data/valid/ready : host input handshake
//   Din, Drdy           : share bundle {share_a, share_b, share_c} + strobe
//   Dvld, Dout          : core result strobe; Dout valid the cycle after Dvld
//   res_data/err        : result to host, err=1 marks a watchdog abort
//   res_valid/ready     : host result handshake
//   busy                : state != IDLE
//   state_dbg           : current FSM state for observation
//
// Handshakes: a transfer happens on a rising CLK edge with EN=1 where both
// valid and ready are high. in_ready is high only in IDLE; res_valid is high
// only in HOLD and, once raised, stays high with res_data/res_err stable
// until a transfer takes place.
// ---------------------------------------------------------------------------
module ti_simon_share_ctrl
    import ti_simon_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int RND_W   = RND_W_DEFAULT,    // must divide DATA_W
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                EN,
    input  logic [31:0]         seed,
    input  logic                seed_ld,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [3*DATA_W-1:0] Din,
    output logic                Drdy,
    input  logic                Dvld,
    input  logic [127:0]        Dout,
    output logic [127:0]        res_data,
    output logic                res_err,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output state_t              state_dbg
);

    localparam int CHUNKS   = DATA_W / RND_W;
    localparam int MASK_CYC = 2 * CHUNKS;
    localparam int MCNT_W   = $clog2(MASK_CYC);
    localparam int WD_W     = wdog_w(TIMEOUT);

    localparam logic [MCNT_W-1:0] MCNT_HALF = MCNT_W'(CHUNKS);
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MASK_CYC - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    state_t              state;
    logic [DATA_W-1:0]   d_reg;
    logic [DATA_W-1:0]   r0;
    logic [DATA_W-1:0]   r1;
    logic [DATA_W-1:0]   sc_reg;
    logic [MCNT_W-1:0]   mcnt;
    logic [WD_W-1:0]     wdog;
    logic                drdy_q;
    logic                din_en;
    logic                res_valid_q;
    logic                res_err_q;
    logic [127:0]        res_data_q;

    logic [RND_W-1:0]    rnd;
    logic [DATA_W-1:0]   r0_sh;
    logic [DATA_W-1:0]   r1_sh;
    logic                prng_load;
    logic                prng_step;

    assign prng_load = EN && (state == S_IDLE) && seed_ld;
    assign prng_step = EN && (state == S_MASK);

    ti_lfsr_prng #(
        .RND_W (RND_W)
    ) u_prng (
        .CLK  (CLK),
        .rst  (rst),
        .seed (seed),
        .load (prng_load),
        .step (prng_step),
        .rnd  (rnd)
    );

    // Mask registers fill MSB-first: earliest PRNG output ends up on top.
    assign r0_sh = (r0 << RND_W) | DATA_W'(rnd);
    assign r1_sh = (r1 << RND_W) | DATA_W'(rnd);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            d_reg       <= '0;
            r0          <= '0;
            r1          <= '0;
            sc_reg      <= '0;
            mcnt        <= '0;
            wdog        <= '0;
            drdy_q      <= 1'b0;
            din_en      <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
        end else if (EN) begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        d_reg <= in_data;
                        mcnt  <= '0;
                        state <= S_MASK;
                    end
                end

                S_MASK: begin
                    if (mcnt < MCNT_HALF) begin
                        r0 <= r0_sh;
                    end else begin
                        r1 <= r1_sh;
                    end
                    mcnt <= mcnt + MCNT_W'(1);
                    if (mcnt == MCNT_LAST) begin
                        // Last chunk of r1 lands this cycle, so use the shifted
                        // value; share_c is then a stable register for the core.
                        sc_reg <= d_reg ^ r0 ^ r1_sh;
                        drdy_q <= 1'b1;
                        din_en <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    drdy_q <= 1'b0;
                    wdog   <= '0;
                    state  <= S_WAIT;
                end

                S_WAIT: begin
                    // Dvld takes priority over the watchdog expiring.
                    if (Dvld) begin
                        state <= S_CAPT;
                    end else if (wdog == WD_LAST) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        din_en      <= 1'b0;
                        d_reg       <= '0;
                        r0          <= '0;
                        r1          <= '0;
                        sc_reg      <= '0;
                        state       <= S_HOLD;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end

                S_CAPT: begin
                    // Erase the unmasked word and all mask material.
                    res_data_q  <= Dout;
                    res_err_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    din_en      <= 1'b0;
                    d_reg       <= '0;
                    r0          <= '0;
                    r1          <= '0;
                    sc_reg      <= '0;
                    state       <= S_HOLD;
                end

                S_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    drdy_q      <= 1'b0;
                    din_en      <= 1'b0;
                    res_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign Drdy      = drdy_q;
    assign Din       = din_en ? {r0, r1, sc_reg} : '0;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign res_valid = res_valid_q;
    assign state_dbg = state;

endmodule

// File: doc/ti_simon_share_ctrl.md
Name: ti_simon_share_ctrl

Overview:
Host-side front end that sits directly upstream of the TI Simon top level.
- Accepts one unmasked 256-bit key/plaintext word from the host.
- Splits it into three Boolean shares using an internal LFSR PRNG.
- Presents the 768-bit share bundle with a Drdy strobe, then waits for Dvld.
- Captures the unmasked 128-bit result and returns it to the host over a valid/ready handshake. A watchdog aborts hung operations.

Parameters:
DATA_W, 256, width of the unmasked input word (one share width); share bundle is 3*DATA_W.
RND_W, 32, PRNG bits produced per MASK cycle; must divide DATA_W.
TIMEOUT, 16384, maximum EN-qualified cycles spent in WAIT before abort.

Ports:
CLK  in  1  system clock
rst  in  1  reset, asynchronous, active-high
EN  in  1  global enable; all state and registers freeze when 0
seed  in  32  PRNG seed
seed_ld  in  1  load seed (honoured in IDLE only)
in_data  in  DATA_W  unmasked word to encrypt
in_valid  in  1  host offers in_data
in_ready  out  1  block accepts in_data
Din  out  3*DATA_W  share bundle {share_a, share_b, share_c} to core
Drdy  out  1  share bundle valid strobe to core
Dvld  in  1  core result-valid
Dout  in  128  core unmasked result; valid the cycle after Dvld
res_data  out  128  result to host
res_err  out  1  result is a timeout abort
res_valid  out  1  result offered to host
res_ready  in  1  host accepts result
busy  out  1  state != IDLE

Behaviour:
- Reset values: every register is cleared, with one exception: the LFSR resets to 32'h1. Outputs after reset are in_ready=1, Drdy=0, res_valid=0, res_err=0, res_data=0, Din=0 and busy=0.
- FSM state advances only on cycles with EN=1. States are IDLE, MASK, ISSUE, WAIT, CAPT and HOLD.
- IDLE: in_ready=1. A cycle with in_valid&in_ready latches in_data into d_reg, clears the mask count and moves to MASK.
  - seed_ld in IDLE loads the LFSR. A zero seed is replaced by 32'h1.
  - seed_ld in any other state is ignored.
- MASK: lasts 2*DATA_W/RND_W cycles (default 16).
  - Each cycle the LFSR is stepped RND_W times (combinationally unrolled). Galois taps are x^32+x^22+x^2+x+1, mask 32'h80200003.
  - The resulting RND_W bits are shifted in: r0 for the first DATA_W/RND_W cycles, then r1.
- Shares are share_a=r0, share_b=r1 and share_c=d_reg^r0^r1. Din={share_a,share_b,share_c}.
  - Din is driven only in ISSUE, WAIT and CAPT, and is 0 otherwise.
  - share_c is computed in the cycle entering ISSUE and registered, so Din is glitch-free.
- ISSUE: Drdy=1. The block leaves ISSUE for WAIT after one EN-high cycle. While EN=0, Drdy stays high; the core ignores it in that case.
- WAIT: a watchdog counter increments each cycle.
  - Dvld=1 moves the FSM to CAPT.
  - If the counter reaches TIMEOUT-1 without Dvld, the FSM moves to HOLD with res_err=1 and res_data=0.
  - If Dvld and timeout occur in the same cycle, Dvld wins.
- CAPT: one cycle. Dout is sampled into res_data and res_err=0. d_reg, r0 and r1 are zeroed to erase unmasked and mask material. The FSM moves to HOLD.
  - On the timeout path the same zeroing happens on entry to HOLD.
- HOLD: res_valid=1, with res_data and res_err stable. res_valid&res_ready returns the FSM to IDLE and clears res_valid.
  - A new in_valid is not accepted in the same cycle (in_ready=0 in HOLD).
- Dvld outside WAIT is ignored.
- Reset mid-operation returns all registers to reset values immediately. No Drdy is issued after reset deasserts.
- Latency from input accept to Drdy: 16 EN cycles in MASK, then Drdy asserts in ISSUE; default total is 17 EN cycles.
- Latency from Dvld to res_valid: 2 EN cycles.

Decomposition:
- Package ti_simon_pkg contains:
  - the state enum;
  - LFSR_TAPS=32'h80200003 and LFSR_RST=32'h1;
  - the default DATA_W, RND_W and TIMEOUT;
  - a function computing the watchdog width as clog2(TIMEOUT).
- Sub-module ti_lfsr_prng (seed load, zero-seed guard, RND_W-step unrolled output, step enable). The FSM, share registers and watchdog stay in the top.

Test Plan:
- Share correctness: seed=32'h1, in_data=256'h0, then 256'h0f0e0d0c0b0a09080706050403020100_63736564207372656c6c657661727420. Require during ISSUE: share_a^share_b^share_c == in_data, share_a != share_b, share_a != 0.
- End-to-end with a behavioural core model that asserts Dvld 4400 cycles after Drdy and Dout=128'h49681b1e1e54fe3f65aa832af84e0bbc one cycle later. Require res_valid 2 cycles after Dvld, with res_data equal to that value and res_err=0. Din must be 0 in HOLD.
- Timeout with TIMEOUT=64: the core model never asserts Dvld. Require HOLD entry exactly 64 EN cycles after WAIT entry, res_err=1, res_data=0.
- EN gating: toggle EN=0 for 5 cycles inside MASK and inside ISSUE. Require Drdy to stay high through the stall, no state advance and identical shares, with timing shifted by exactly the stalled cycles.
- Backpressure and ignored inputs:
  - Hold res_ready=0 for 10 cycles: res_valid and res_data stay stable and in_ready=0.
  - Pulse seed_ld in WAIT: no effect on the next operation's shares.
  - A spurious Dvld in IDLE: ignored.
- Reset mid-WAIT: assert rst for 1 cycle. Require reset values immediately, busy=0, and no Drdy or res_valid until a new in_valid is accepted.
